// File: rtl/key_pkg.sv
// Shared types and default 50 MHz timing for the key front end.
// Provides the hold-state enum and default cycle counts.
package key_pkg;

  typedef enum logic [1:0] {
    REL  = 2'd0,
    HELD = 2'd1,
    LONG = 2'd2
  } hold_st_e;

  localparam int unsigned DEF_N_KEYS       = 4;
  localparam int unsigned DEF_DEBOUNCE_CYC = 1_000_000;
  localparam int unsigned DEF_LONG_CYC     = 50_000_000;
  localparam int unsigned DEF_REPEAT_CYC   = 10_000_000;

endpackage

// File: rtl/key_debounce_multi_if.sv
// Key pin / event bundle between the pins, the debouncer and its consumer.
// slave: debouncer side (takes key_n, drives events); master: consumer side.
interface key_debounce_multi_if #(
  parameter int unsigned N_KEYS = 4
);

  logic [N_KEYS-1:0] key_n;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] key_press;
  logic [N_KEYS-1:0] key_release;
  logic [N_KEYS-1:0] key_long;
  logic [N_KEYS-1:0] key_repeat;

  modport slave (
    input  key_n,
    output key_level,
    output key_press,
    output key_release,
    output key_long,
    output key_repeat
  );

  modport master (
    output key_n,
    input  key_level,
    input  key_press,
    input  key_release,
    input  key_long,
    input  key_repeat
  );

endinterface

// File: rtl/key_chan.sv
// One key channel: 2-FF sync, stable-time debounce, REL/HELD/LONG hold FSM.
// Ports: clk, rst (sync, high), key_n in; level/press/release/long/repeat out.
// Auto-repeat built only when KEY_REPEAT_EN is defined.
module key_chan
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int unsigned LONG_CYC     = DEF_LONG_CYC
`ifdef KEY_REPEAT_EN
  ,
  parameter int unsigned REPEAT_CYC   = DEF_REPEAT_CYC
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_long,
  output logic key_repeat
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYC);
  localparam int unsigned LW = $clog2(LONG_CYC);
  localparam logic [DW-1:0] D_MAX = DW'(DEBOUNCE_CYC - 1);
  localparam logic [LW-1:0] L_MAX = LW'(LONG_CYC - 1);

  logic [1:0]    sync_q;
  logic          sync;
  logic          stable_q;
  logic [DW-1:0] db_cnt;
  logic          flip;
  logic          rise;
  logic          fall;

  hold_st_e      st_q;
  logic [LW-1:0] hold_cnt;
  logic          press_q;
  logic          rel_q;
  logic          long_q;

  // Idle pin is high, so the synchroniser resets to 1 (released).
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], key_n};
    end
  end

  assign sync = ~sync_q[1];

  // Flip on the DEBOUNCE_CYC-th consecutive cycle of disagreement.
  assign flip = (sync != stable_q) && (db_cnt == D_MAX);
  assign rise = flip & sync;
  assign fall = flip & ~sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      stable_q <= 1'b0;
      db_cnt   <= '0;
    end else if (sync == stable_q) begin
      db_cnt   <= '0;
    end else if (flip) begin
      stable_q <= sync;
      db_cnt   <= '0;
    end else begin
      db_cnt   <= db_cnt + 1'b1;
    end
  end

`ifdef KEY_REPEAT_EN
  localparam int unsigned RW = $clog2(REPEAT_CYC);
  localparam logic [RW-1:0] R_MAX = RW'(REPEAT_CYC - 1);

  logic [RW-1:0] rep_cnt;
  logic          rep_q;
`endif

  // Hold FSM. A release in the same cycle a count expires wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q     <= REL;
      hold_cnt <= '0;
      press_q  <= 1'b0;
      rel_q    <= 1'b0;
      long_q   <= 1'b0;
`ifdef KEY_REPEAT_EN
      rep_cnt  <= '0;
      rep_q    <= 1'b0;
`endif
    end else begin
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      long_q  <= 1'b0;
`ifdef KEY_REPEAT_EN
      rep_q   <= 1'b0;
`endif
      unique case (st_q)
        REL: begin
          hold_cnt <= '0;
          if (rise) begin
            st_q    <= HELD;
            press_q <= 1'b1;
          end
        end
        HELD: begin
          if (fall) begin
            st_q     <= REL;
            rel_q    <= 1'b1;
            hold_cnt <= '0;
          end else if (hold_cnt == L_MAX) begin
            st_q     <= LONG;
            long_q   <= 1'b1;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        LONG: begin
          if (fall) begin
            st_q    <= REL;
            rel_q   <= 1'b1;
`ifdef KEY_REPEAT_EN
            rep_cnt <= '0;
          end else if (rep_cnt == R_MAX) begin
            rep_q   <= 1'b1;
            rep_cnt <= '0;
          end else begin
            rep_cnt <= rep_cnt + 1'b1;
`endif
          end
        end
        default: begin
          st_q     <= REL;
          hold_cnt <= '0;
        end
      endcase
    end
  end

  assign key_level   = stable_q;
  assign key_press   = press_q;
  assign key_release = rel_q;
  assign key_long    = long_q;
`ifdef KEY_REPEAT_EN
  assign key_repeat  = rep_q;
`else
  assign key_repeat  = 1'b0;
`endif

endmodule

// File: rtl/key_debounce_multi.sv
// Multi-channel key front end: N_KEYS independent key_chan instances.
// Ports: clk, rst (sync, high), kif (slave). Option macro: KEY_REPEAT_EN.
module key_debounce_multi
  import key_pkg::*;
#(
  parameter int unsigned N_KEYS       = DEF_N_KEYS,
  parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int unsigned LONG_CYC     = DEF_LONG_CYC,
  parameter int unsigned REPEAT_CYC   = DEF_REPEAT_CYC
) (
  input  logic                 clk,
  input  logic                 rst,
  key_debounce_multi_if.slave  kif
);

  if (N_KEYS < 1) begin : g_bad_n
    $error("N_KEYS must be at least 1");
  end
  if (DEBOUNCE_CYC < 2) begin : g_bad_db
    $error("DEBOUNCE_CYC must be at least 2");
  end
  if (LONG_CYC <= DEBOUNCE_CYC) begin : g_bad_long
    $error("LONG_CYC must exceed DEBOUNCE_CYC");
  end
  if (REPEAT_CYC < 2) begin : g_bad_rep
    $error("REPEAT_CYC must be at least 2");
  end

  logic [N_KEYS-1:0] level_v;
  logic [N_KEYS-1:0] press_v;
  logic [N_KEYS-1:0] rel_v;
  logic [N_KEYS-1:0] long_v;
  logic [N_KEYS-1:0] rep_v;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
    key_chan #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .LONG_CYC     (LONG_CYC)
`ifdef KEY_REPEAT_EN
      ,
      .REPEAT_CYC   (REPEAT_CYC)
`endif
    ) u_chan (
      .clk         (clk),
      .rst         (rst),
      .key_n       (kif.key_n[i]),
      .key_level   (level_v[i]),
      .key_press   (press_v[i]),
      .key_release (rel_v[i]),
      .key_long    (long_v[i]),
      .key_repeat  (rep_v[i])
    );
  end

  assign kif.key_level   = level_v;
  assign kif.key_press   = press_v;
  assign kif.key_release = rel_v;
  assign kif.key_long    = long_v;
  assign kif.key_repeat  = rep_v;

endmodule

// File: tb/tb_key_debounce_multi.sv
// Bench for key_debounce_multi: directed timing plus random pin activity.
// Outputs compared every cycle with an age/run-length reference model.
module tb_key_debounce_multi;

  localparam int N = 2;
  localparam int D = 4;
  localparam int L = 20;
  localparam int R = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  key_debounce_multi_if #(.N_KEYS(N)) kif ();

  key_debounce_multi #(
    .N_KEYS       (N),
    .DEBOUNCE_CYC (D),
    .LONG_CYC     (L),
    .REPEAT_CYC   (R)
  ) dut (
    .clk (clk),
    .rst (rst),
    .kif (kif)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  // Reference: pin seen two edges late; level accepted after D
  // consecutive disagreeing edges; events from age since press.
  int p1 [N];
  int p2 [N];
  int lvl [N];
  int run [N];
  int age [N];
  logic [N-1:0] e_lvl, e_pr, e_rl, e_lg, e_rp;

  task automatic model_edge();
    e_pr = '0;
    e_rl = '0;
    e_lg = '0;
    e_rp = '0;
    for (int c = 0; c < N; c++) begin
      if (rst) begin
        p1[c] = 1; p2[c] = 1;
        lvl[c] = 0; run[c] = 0; age[c] = -1;
      end else begin
        int s;
        s = (p2[c] == 0) ? 1 : 0;
        if (s != lvl[c]) run[c]++;
        else run[c] = 0;
        if (run[c] == D) begin
          lvl[c] = s;
          run[c] = 0;
          if (s == 1) begin
            e_pr[c] = 1'b1;
            age[c] = 0;
          end else begin
            e_rl[c] = 1'b1;
            age[c] = -1;
          end
        end else if (age[c] >= 0) begin
          age[c]++;
          if (age[c] == L) e_lg[c] = 1'b1;
`ifdef KEY_REPEAT_EN
          if (age[c] > L && (age[c] - L) % R == 0) e_rp[c] = 1'b1;
`endif
        end
        p2[c] = p1[c];
        p1[c] = int'(kif.key_n[c]);
      end
      e_lvl[c] = (lvl[c] != 0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
    chk("level",   32'(kif.key_level),   32'(e_lvl));
    chk("press",   32'(kif.key_press),   32'(e_pr));
    chk("release", 32'(kif.key_release), 32'(e_rl));
    chk("long",    32'(kif.key_long),    32'(e_lg));
    chk("repeat",  32'(kif.key_repeat),  32'(e_rp));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // which: 0 press, 1 release, 2 long, 3 repeat
  task automatic wait_ev(input int which, input int ch,
                         input int limit, output int n);
    logic hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < limit) begin
      tick();
      n++;
      case (which)
        0: hit = kif.key_press[ch];
        1: hit = kif.key_release[ch];
        2: hit = kif.key_long[ch];
        default: hit = kif.key_repeat[ch];
      endcase
    end
  endtask

  int n;
  int dur [N];

  initial begin
    kif.key_n = '1;
    rst = 1'b1;
    @(negedge clk);
    ticks(3);
    rst = 1'b0;
    ticks(3);

    kif.key_n[0] = 1'b0;
    wait_ev(0, 0, 100, n);
    chk("press_lat", n, 6);
    wait_ev(2, 0, 100, n);
    chk("long_lat", n, L);
`ifdef KEY_REPEAT_EN
    wait_ev(3, 0, 100, n);
    chk("rep1_lat", n, R);
    wait_ev(3, 0, 100, n);
    chk("rep2_lat", n, R);
`endif
    ticks(3);
    kif.key_n[0] = 1'b1;
    wait_ev(1, 0, 100, n);
    chk("rel_lat", n, 6);
    ticks(40);

    kif.key_n[0] = 1'b0; ticks(3);
    kif.key_n[0] = 1'b1; ticks(1);
    kif.key_n[0] = 1'b0;
    wait_ev(0, 0, 100, n);
    chk("bounce_lat", n, 6);
    kif.key_n[0] = 1'b1;
    ticks(12);

    kif.key_n = 2'b00;
    wait_ev(0, 0, 100, n);
    chk("both_press", 32'(kif.key_press), 32'h3);
    wait_ev(2, 1, 100, n);
    chk("long1_lat", n, L);
    ticks(5);
    rst = 1'b1;
    ticks(2);
    chk("rst_level", 32'(kif.key_level), 0);
    rst = 1'b0;
    wait_ev(0, 1, 100, n);
    chk("redetect", n, 6);
    kif.key_n = 2'b11;
    ticks(12);

    for (int c = 0; c < N; c++) dur[c] = 0;
    for (int t = 0; t < 4000; t++) begin
      for (int c = 0; c < N; c++) begin
        if (dur[c] == 0) begin
          kif.key_n[c] = ~kif.key_n[c];
          if ($urandom_range(1, 0) == 1) dur[c] = $urandom_range(3, 1);
          else dur[c] = $urandom_range(70, 5);
        end
        dur[c]--;
      end
      rst = ($urandom_range(799, 0) == 0);
      tick();
    end
    rst = 1'b0;
    ticks(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
